// File: rtl/demux_router.sv
// demux_router: registered 1-to-3 demultiplexer with one-hot select checking.
//
// Steers ip to one of op1..op3 under {sel3,sel2,sel1}. Illegal selects (two or
// more bits set) are flagged, counted and, when they repeat back to back,
// lock out routing until err_clr.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset (priority over everything)
//   ip         data to route
//   sel1..3    lane selects, expected one-hot or all-zero
//   err_clr    clears error state and returns FSM to RUN
//   op1..3     registered lane data; unselected lanes hold
//   op_valid   one-cycle strobe, bit k-1 = opk updated
//   sel_err    one-cycle pulse for a counted illegal select
//   err_sticky set by any counted illegal select
//   err_count  saturating illegal-select count
//   locked     high while in LOCKED
//
// state  | meaning
// RUN    | normal routing, tracking consecutive illegal selects
// LOCKED | routing disabled after LOCK_THRESH back-to-back illegal selects
module demux_router #(
   parameter int WIDTH       = 4,
   parameter int ERR_CNT_W   = 4,
   parameter int LOCK_THRESH = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     ip,
   input  logic                 sel1,
   input  logic                 sel2,
   input  logic                 sel3,
   input  logic                 err_clr,
   output logic [WIDTH-1:0]     op1,
   output logic [WIDTH-1:0]     op2,
   output logic [WIDTH-1:0]     op3,
   output logic [2:0]           op_valid,
   output logic                 sel_err,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 locked
);

   typedef enum logic {RUN = 1'b0, LOCKED = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_consec;
   logic [2:0]            w_consec_nxt;
   logic [2:0]            w_sel;
   logic                  w_legal;
   logic                  w_illegal;
   logic                  w_route;
   logic                  w_count_err;
   logic [WIDTH-1:0]      r_op1;
   logic [WIDTH-1:0]      r_op2;
   logic [WIDTH-1:0]      r_op3;
   logic [2:0]            r_op_valid;
   logic                  r_sel_err;
   logic                  r_err_sticky;
   logic [ERR_CNT_W-1:0]  r_err_count;

   assign w_sel = {sel3, sel2, sel1};

   always_comb begin
      w_legal      = 1'b0;
      w_illegal    = 1'b0;
      w_route      = 1'b0;
      w_count_err  = 1'b0;
      w_state_nxt  = r_state;
      w_consec_nxt = r_consec;

      // One-hot test: nonzero with no second bit set.
      w_legal   = (w_sel != 3'b000) && ((w_sel & (w_sel - 3'd1)) == 3'b000);
      w_illegal = (w_sel != 3'b000) && !w_legal;

      // A legal select routes only when RUN at this edge, even alongside err_clr.
      w_route     = w_legal && (r_state == RUN);
      w_count_err = w_illegal && !err_clr;

      if (err_clr) begin
         w_state_nxt  = RUN;
         w_consec_nxt = 3'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_illegal) begin
                  w_consec_nxt = r_consec + 3'd1;
                  if ((r_consec + 3'd1) == 3'(LOCK_THRESH))
                     w_state_nxt = LOCKED;
               end else begin
                  w_consec_nxt = 3'd0;
               end
            end
            LOCKED: begin
               w_state_nxt  = LOCKED;
               w_consec_nxt = r_consec;
            end
            default: begin
               w_state_nxt  = RUN;
               w_consec_nxt = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= RUN;
         r_consec <= 3'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_consec <= w_consec_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_op1        <= '0;
         r_op2        <= '0;
         r_op3        <= '0;
         r_op_valid   <= 3'b000;
         r_sel_err    <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_op_valid <= w_route ? w_sel : 3'b000;
         r_sel_err  <= w_count_err;
         if (w_route && sel1) r_op1 <= ip;
         if (w_route && sel2) r_op2 <= ip;
         if (w_route && sel3) r_op3 <= ip;
         if (err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
         end else if (w_count_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != '1)
               r_err_count <= r_err_count + 1'b1;
         end
      end
   end

   assign op1        = r_op1;
   assign op2        = r_op2;
   assign op3        = r_op3;
   assign op_valid   = r_op_valid;
   assign sel_err    = r_sel_err;
   assign err_sticky = r_err_sticky;
   assign err_count  = r_err_count;
   assign locked     = (r_state == LOCKED);

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;

   logic       clock = 1'b0;
   logic       reset;
   logic       reset2;
   logic [3:0] ip;
   logic       sel1, sel2, sel3;
   logic       err_clr;

   logic [3:0] op1, op2, op3;
   logic [2:0] op_valid;
   logic       sel_err, err_sticky, locked;
   logic [3:0] err_count;

   logic [3:0] b_op1, b_op2, b_op3;
   logic [2:0] b_op_valid;
   logic       b_sel_err, b_err_sticky, b_locked;
   logic [1:0] b_err_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   demux_router #(.WIDTH(4), .ERR_CNT_W(4), .LOCK_THRESH(3)) dut (
      .clock(clock), .reset(reset), .ip(ip),
      .sel1(sel1), .sel2(sel2), .sel3(sel3), .err_clr(err_clr),
      .op1(op1), .op2(op2), .op3(op3), .op_valid(op_valid),
      .sel_err(sel_err), .err_sticky(err_sticky), .err_count(err_count),
      .locked(locked)
   );

   demux_router #(.WIDTH(4), .ERR_CNT_W(2), .LOCK_THRESH(3)) dut2 (
      .clock(clock), .reset(reset2), .ip(ip),
      .sel1(sel1), .sel2(sel2), .sel3(sel3), .err_clr(err_clr),
      .op1(b_op1), .op2(b_op2), .op3(b_op3), .op_valid(b_op_valid),
      .sel_err(b_sel_err), .err_sticky(b_err_sticky), .err_count(b_err_count),
      .locked(b_locked)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] s, input logic [3:0] d, input logic clr);
      {sel3, sel2, sel1} = s;
      ip      = d;
      err_clr = clr;
   endtask

   // Advance one edge; sample and re-drive 1 time unit after it.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      reset2 = 1'b1;
      drive(3'b001, 4'hF, 1'b0);
      #1;
      cyc();
      cyc();
      reset = 1'b0;
      drive(3'b000, 4'h0, 1'b0);
      chk("rst_op1", op1, 0);
      chk("rst_op2", op2, 0);
      chk("rst_op3", op3, 0);
      chk("rst_valid", op_valid, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_sticky", err_sticky, 0);
      chk("rst_selerr", sel_err, 0);
      chk("rst_locked", locked, 0);

      // Basic routing, one lane per cycle.
      drive(3'b001, 4'd1, 1'b0); cyc();
      chk("r1_op1", op1, 1); chk("r1_valid", op_valid, 3'b001);
      drive(3'b010, 4'd2, 1'b0); cyc();
      chk("r2_op2", op2, 2); chk("r2_valid", op_valid, 3'b010); chk("r2_op1hold", op1, 1);
      drive(3'b100, 4'd4, 1'b0); cyc();
      chk("r3_op3", op3, 4); chk("r3_valid", op_valid, 3'b100); chk("r3_op2hold", op2, 2);
      drive(3'b000, 4'd4, 1'b0); cyc();
      chk("idle_valid", op_valid, 0); chk("idle_op3", op3, 4);

      // Select sweep, idle between steps so illegal selects are not back to back.
      for (int s = 0; s < 8; s++) begin
         logic [2:0] sv;
         logic [2:0] ev;
         logic       ee;
         sv = 3'(s);
         ev = (s == 1 || s == 2 || s == 4) ? sv : 3'b000;
         ee = (s == 3 || s == 5 || s == 6 || s == 7);
         drive(sv, 4'b0101, 1'b0); cyc();
         chk($sformatf("sw%0d_valid", s), op_valid, ev);
         chk($sformatf("sw%0d_selerr", s), sel_err, ee);
         drive(3'b000, 4'b0101, 1'b0); cyc();
      end
      chk("sw_cnt", err_count, 4);
      chk("sw_sticky", err_sticky, 1);
      chk("sw_locked", locked, 0);
      chk("sw_op1", op1, 5); chk("sw_op2", op2, 5); chk("sw_op3", op3, 5);

      drive(3'b000, 4'd0, 1'b1); cyc();
      chk("clr_cnt", err_count, 0); chk("clr_sticky", err_sticky, 0);

      // Three back-to-back illegal selects lock the router.
      drive(3'b011, 4'd0, 1'b0); cyc();
      chk("lk1_cnt", err_count, 1); chk("lk1_locked", locked, 0); chk("lk1_selerr", sel_err, 1);
      cyc();
      chk("lk2_cnt", err_count, 2); chk("lk2_locked", locked, 0);
      cyc();
      chk("lk3_cnt", err_count, 3); chk("lk3_locked", locked, 1);
      drive(3'b001, 4'd9, 1'b0); cyc();
      chk("lkr_op1", op1, 5); chk("lkr_valid", op_valid, 0); chk("lkr_selerr", sel_err, 0);
      chk("lkr_locked", locked, 1);
      drive(3'b111, 4'd9, 1'b0); cyc();
      chk("lki_cnt", err_count, 4); chk("lki_selerr", sel_err, 1); chk("lki_locked", locked, 1);
      drive(3'b000, 4'd9, 1'b1); cyc();
      chk("ulk_locked", locked, 0); chk("ulk_cnt", err_count, 0);
      drive(3'b001, 4'd9, 1'b0); cyc();
      chk("ulk_op1", op1, 9); chk("ulk_valid", op_valid, 3'b001);

      // err_clr beats an illegal select in the same cycle.
      drive(3'b110, 4'd0, 1'b0); cyc();
      chk("pc_cnt", err_count, 1); chk("pc_sticky", err_sticky, 1);
      drive(3'b111, 4'd0, 1'b1); cyc();
      chk("ci_selerr", sel_err, 0); chk("ci_cnt", err_count, 0); chk("ci_sticky", err_sticky, 0);
      chk("ci_locked", locked, 0);

      // err_clr with a legal select routes only from RUN.
      drive(3'b010, 4'd3, 1'b1); cyc();
      chk("cr_op2", op2, 3); chk("cr_valid", op_valid, 3'b010);
      drive(3'b101, 4'd0, 1'b0); cyc(); cyc(); cyc();
      chk("cl_locked", locked, 1);
      drive(3'b100, 4'd7, 1'b1); cyc();
      chk("cl_op3", op3, 5); chk("cl_valid", op_valid, 0); chk("cl_unlock", locked, 0);

      // Narrow counter instance: saturation, then mid-sequence reset.
      drive(3'b000, 4'd0, 1'b0);
      reset2 = 1'b0;
      cyc();
      chk("b_rst_cnt", b_err_count, 0);
      for (int k = 1; k <= 6; k++) begin
         drive(3'b011, 4'd0, 1'b0); cyc();
         chk($sformatf("b_sat%0d_cnt", k), b_err_count, (k < 3) ? k : 3);
         drive(3'b000, 4'd0, 1'b0); cyc();
      end
      chk("b_sticky", b_err_sticky, 1);
      chk("b_locked", b_locked, 0);
      reset2 = 1'b1;
      drive(3'b111, 4'd0, 1'b0); cyc();
      chk("b_mr_cnt", b_err_count, 0);
      chk("b_mr_sticky", b_err_sticky, 0);
      chk("b_mr_selerr", b_sel_err, 0);
      chk("b_mr_locked", b_locked, 0);
      chk("b_mr_op1", b_op1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
